// File: rtl/cu_mcycle_sequencer_pkg.sv
// Shared control-unit definitions for the M-cycle sequencer: run-state enum,
// T-state constants and the dispatch-cycle indices that fire side effects.
package cu_mcycle_sequencer_pkg;

    localparam int T_PER_M_DEFAULT = 4;
    localparam int T_LAST          = T_PER_M_DEFAULT - 1;

    localparam logic [2:0] INT_CLR_IME_CYCLE = 3'd0;
    localparam logic [2:0] INT_ACK_CYCLE     = 3'd3;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_INT  = 2'd2
    } cu_state_e;

    // Width of the T-state counter; never below one bit.
    function automatic int tstate_width(input int t_per_m);
        return (t_per_m < 2) ? 1 : $clog2(t_per_m);
    endfunction

endpackage

// File: rtl/cu_mcycle_sequencer_if.sv
// Bundle between the decoder / interrupt controller side (master) and the
// M-cycle sequencer (slave).
interface cu_mcycle_sequencer_if
    import cu_mcycle_sequencer_pkg::*;
#(
    parameter int T_PER_M = T_LAST + 1
) ();
    localparam int TW = tstate_width(T_PER_M);

    logic          i_Stall;
    logic          i_InstrDone;
    logic          i_HaltReq;
    logic          i_IntPending;
    logic          i_IME;

    logic [TW-1:0] o_TState;
    logic          o_MCycleEnd;
    logic          o_StepEn;
    logic          o_StepReset;
    logic          o_Halted;
    logic          o_IntDispatch;
    logic [2:0]    o_DispCycle;
    logic          o_ClrIME;
    logic          o_IntAck;

    modport master (
        output i_Stall, i_InstrDone, i_HaltReq, i_IntPending, i_IME,
        input  o_TState, o_MCycleEnd, o_StepEn, o_StepReset, o_Halted,
               o_IntDispatch, o_DispCycle, o_ClrIME, o_IntAck
    );

    modport slave (
        input  i_Stall, i_InstrDone, i_HaltReq, i_IntPending, i_IME,
        output o_TState, o_MCycleEnd, o_StepEn, o_StepReset, o_Halted,
               o_IntDispatch, o_DispCycle, o_ClrIME, o_IntAck
    );

endinterface

// File: rtl/cu_tstate_counter.sv
// Stall-aware T-state counter: wraps every T_PER_M clocks and holds in the
// last T-state while the bus is stalled.
module cu_tstate_counter
    import cu_mcycle_sequencer_pkg::*;
#(
    parameter int T_PER_M = T_LAST + 1
) (
    input  logic                           i_Clk,
    input  logic                           i_nRst,
    input  logic                           i_Stall,
    output logic [tstate_width(T_PER_M)-1:0] o_TState,
    output logic                           o_MCycleEnd
);
    localparam int            TW     = tstate_width(T_PER_M);
    localparam logic [TW-1:0] T_MAX  = TW'(T_PER_M - 1);

    logic at_last;

    assign at_last     = (o_TState == T_MAX);
    assign o_MCycleEnd = at_last & ~i_Stall;

    // NOTE: state registers use non-blocking assignments and clear on the
    // asynchronous reset edge, so every flop is defined before the first clock.
    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            o_TState <= '0;
        end else if (!(at_last && i_Stall)) begin
            // T_PER_M is a power of two, so the natural overflow is the wrap.
            o_TState <= o_TState + 1'b1;
        end
    end

endmodule

// File: rtl/cu_mcycle_sequencer.sv
// SM83 machine-cycle sequencer: run state (RUN/HALT/INT), dispatch counter
// and the Mealy enable/reset strobes for the control-unit step counter.
module cu_mcycle_sequencer
    import cu_mcycle_sequencer_pkg::*;
#(
    parameter int T_PER_M      = T_LAST + 1,
    parameter int INT_M_CYCLES = 5
) (
    input  logic                 i_Clk,
    input  logic                 i_nRst,
    cu_mcycle_sequencer_if.slave bus
);
    localparam int         TW        = tstate_width(T_PER_M);
    localparam logic [2:0] DISP_LAST = 3'(INT_M_CYCLES - 1);

    cu_state_e     state;
    logic [2:0]    disp_cycle;
    logic          clr_ime;
    logic          int_ack;
    logic [TW-1:0] tstate;
    logic          mcycle_end;
    logic          disp_last;
    logic          step_en;
    logic          step_reset;

    cu_tstate_counter #(
        .T_PER_M (T_PER_M)
    ) u_tstate (
        .i_Clk       (i_Clk),
        .i_nRst      (i_nRst),
        .i_Stall     (bus.i_Stall),
        .o_TState    (tstate),
        .o_MCycleEnd (mcycle_end)
    );

    assign disp_last = (disp_cycle == DISP_LAST);

    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            state      <= ST_RUN;
            disp_cycle <= '0;
            clr_ime    <= 1'b0;
            int_ack    <= 1'b0;
        end else begin
            clr_ime <= 1'b0;
            int_ack <= 1'b0;
            if (mcycle_end) begin
                case (state)
                    ST_RUN: begin
                        if (bus.i_InstrDone && bus.i_IntPending && bus.i_IME) begin
                            state <= ST_INT;
                        end else if (bus.i_InstrDone && bus.i_HaltReq && !bus.i_IntPending) begin
                            state <= ST_HALT;
                        end
                    end
                    ST_HALT: begin
                        if (bus.i_IntPending) begin
                            state <= bus.i_IME ? ST_INT : ST_RUN;
                        end
                    end
                    ST_INT: begin
                        // Side-effect pulses are high for the clock after the
                        // edge that closes their dispatch cycle.
                        clr_ime <= (disp_cycle == INT_CLR_IME_CYCLE);
                        int_ack <= (disp_cycle == INT_ACK_CYCLE);
                        if (disp_last) begin
                            state      <= ST_RUN;
                            disp_cycle <= '0;
                        end else begin
                            disp_cycle <= disp_cycle + 3'd1;
                        end
                    end
                    default: state <= ST_RUN;
                endcase
            end
        end
    end

    // NOTE: both strobes get a default before the case, so no path leaves
    // them unassigned and no latch is inferred.
    always_comb begin
        step_en    = 1'b0;
        step_reset = 1'b0;
        if (mcycle_end) begin
            case (state)
                ST_RUN: begin
                    step_en    = 1'b1;
                    step_reset = bus.i_InstrDone;
                end
                ST_HALT: begin
                    step_en    = bus.i_IntPending;
                    step_reset = bus.i_IntPending;
                end
                ST_INT: begin
                    step_en    = disp_last;
                    step_reset = disp_last;
                end
                default: begin
                    step_en    = 1'b0;
                    step_reset = 1'b0;
                end
            endcase
        end
    end

    assign bus.o_TState      = tstate;
    assign bus.o_MCycleEnd   = mcycle_end;
    assign bus.o_StepEn      = step_en;
    assign bus.o_StepReset   = step_reset;
    assign bus.o_Halted      = (state == ST_HALT);
    assign bus.o_IntDispatch = (state == ST_INT);
    assign bus.o_DispCycle   = disp_cycle;
    assign bus.o_ClrIME      = clr_ime;
    assign bus.o_IntAck      = int_ack;

endmodule

// File: tb/tb_cu_mcycle_sequencer.sv
// Scoreboard bench for cu_mcycle_sequencer: the stimulus queues one expected
// record per M-cycle, the monitor pops one at every o_MCycleEnd.
module tb_cu_mcycle_sequencer;
    localparam int T_PER_M = 4;
    localparam int TL      = T_PER_M - 1;

    typedef struct {
        logic       en;
        logic       rs;
        logic       halted;
        logic       intd;
        logic [2:0] disp;
        logic       clr;
        logic       ack;
        int         len;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t sb[$];

    cu_mcycle_sequencer_if #(.T_PER_M(T_PER_M)) bus ();

    cu_mcycle_sequencer #(
        .T_PER_M      (T_PER_M),
        .INT_M_CYCLES (5)
    ) dut (
        .i_Clk  (clk),
        .i_nRst (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tstate"},   int'(bus.o_TState), 0);
        check({tag, "_mend"},     int'(bus.o_MCycleEnd), 0);
        check({tag, "_step_en"},  int'(bus.o_StepEn), 0);
        check({tag, "_step_rst"}, int'(bus.o_StepReset), 0);
        check({tag, "_halted"},   int'(bus.o_Halted), 0);
        check({tag, "_intdisp"},  int'(bus.o_IntDispatch), 0);
        check({tag, "_disp"},     int'(bus.o_DispCycle), 0);
        check({tag, "_clrime"},   int'(bus.o_ClrIME), 0);
        check({tag, "_intack"},   int'(bus.o_IntAck), 0);
    endtask

    // One M-cycle: queue its expected end-of-cycle record, then drive inputs
    // from T0; a stall is raised from T0 so its early part must be ignored.
    task automatic mc(input logic done, input logic halt, input logic pend,
                      input logic ime, input int nst,
                      input logic en, input logic rs, input logic hl,
                      input logic idp, input int dc,
                      input logic clr, input logic ack);
        exp_t e;
        e.en = en; e.rs = rs; e.halted = hl; e.intd = idp;
        e.disp = 3'(dc); e.clr = clr; e.ack = ack; e.len = T_PER_M + nst;
        sb.push_back(e);
        bus.i_InstrDone  = done;
        bus.i_HaltReq    = halt;
        bus.i_IntPending = pend;
        bus.i_IME        = ime;
        for (int k = 0; k < T_PER_M + nst; k++) begin
            bus.i_Stall = (nst > 0) && (k < TL + nst);
            @(posedge clk);
            #1;
        end
        bus.i_Stall = 1'b0;
    endtask

    // Five dispatch M-cycles; optional stall on one of them.
    task automatic int_seq(input logic pend, input logic ime, input int stall_at);
        for (int d = 0; d < 5; d++) begin
            mc(1'b0, 1'b0, pend, ime, (d == stall_at) ? 2 : 0,
               d == 4, d == 4, 1'b0, 1'b1, d, d == 0, d == 3);
        end
    endtask

    // Monitor: tracks the position inside the M-cycle, checks T-state,
    // idle strobes, pulses and pops the scoreboard at each M-cycle end.
    initial begin
        int   k;
        logic pulse_due;
        exp_t cur;
        k = 0;
        pulse_due = 1'b0;
        cur = '{default: '0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                k = 0;
                pulse_due = 1'b0;
            end else begin
                check("tstate", int'(bus.o_TState), (k < TL) ? k : TL);
                if (pulse_due) begin
                    check("clr_ime", int'(bus.o_ClrIME), int'(cur.clr));
                    check("int_ack", int'(bus.o_IntAck), int'(cur.ack));
                    pulse_due = 1'b0;
                end else begin
                    check("clr_ime_idle", int'(bus.o_ClrIME), 0);
                    check("int_ack_idle", int'(bus.o_IntAck), 0);
                end
                if (bus.o_MCycleEnd) begin
                    if (sb.size() == 0) begin
                        check("unexpected_mcycle_end", 1, 0);
                    end else begin
                        cur = sb.pop_front();
                        check("step_en",    int'(bus.o_StepEn), int'(cur.en));
                        check("step_reset", int'(bus.o_StepReset), int'(cur.rs));
                        check("halted",     int'(bus.o_Halted), int'(cur.halted));
                        check("int_disp",   int'(bus.o_IntDispatch), int'(cur.intd));
                        check("disp_cycle", int'(bus.o_DispCycle), int'(cur.disp));
                        check("mcycle_len", k + 1, cur.len);
                        pulse_due = 1'b1;
                    end
                    k = 0;
                end else begin
                    check("step_en_idle",  int'(bus.o_StepEn), 0);
                    check("step_rst_idle", int'(bus.o_StepReset), 0);
                    k++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        bus.i_Stall = 1'b0; bus.i_InstrDone = 1'b0; bus.i_HaltReq = 1'b0;
        bus.i_IntPending = 1'b1; bus.i_IME = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset_hold");
        bus.i_IntPending = 1'b0; bus.i_IME = 1'b0;
        rst_n = 1'b1;

        // Plain 3-M-cycle instruction: StepEn at clocks 3, 7, 11; reset at 11.
        mc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        mc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        mc(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);

        // Three stalled clocks at T3 stretch the M-cycle to 7 clocks.
        mc(0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
        mc(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);

        // Interrupt dispatch; pending/IME stay high and must be ignored.
        mc(1, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        int_seq(1'b1, 1'b1, -1);
        mc(0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);

        // HALT for 10 M-cycles, then wake with IME=0 back to RUN.
        mc(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        repeat (10) mc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        mc(0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
        mc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        // HALT then wake with IME=1 into dispatch (one stalled dispatch cycle).
        mc(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        repeat (2) mc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        mc(0, 0, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0);
        int_seq(1'b0, 1'b0, 2);
        mc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        // Halt-bug case: HALT with pending interrupt and IME=0 stays in RUN.
        mc(1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        mc(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        // Async reset two clocks into dispatch cycle 2.
        mc(1, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        mc(0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0);
        mc(0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset_intdisp", int'(bus.o_IntDispatch), 1);
        check("pre_reset_disp",    int'(bus.o_DispCycle), 2);
        check("pre_reset_tstate",  int'(bus.o_TState), 2);
        rst_n = 1'b0;
        #1 check_all_zero("mid_reset");
        repeat (3) @(posedge clk);
        #1 check_all_zero("mid_reset_hold");
        rst_n = 1'b1;
        #1 check_all_zero("post_release");
        mc(0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        mc(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
